// File: rtl/alu_mdu_seq.sv
// alu_mdu_seq: ALU op decoder/executor with single-cycle register-output ALU ops
// and an iterative unsigned multiply/divide unit holding HI/LO.
//
// Handshake: an operation transfers on a rising clk edge where in_valid and
// in_ready are both high; in_valid is ignored while in_ready is low. out_valid
// is a one-cycle pulse with no backpressure, so result/zero/err/hi/lo must be
// sampled in that cycle.
module alu_mdu_seq #(
    parameter int WIDTH      = 32,
    parameter bit ENABLE_MDU = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       alu_op,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             err,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [1:0]       dbg_state
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW-1:0] LAST_ITER = SHW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_err;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    // Working registers: r_acc is the partial product / partial remainder,
    // r_wlo the shifting multiplier / quotient, r_opnd the captured
    // multiplicand / divisor.
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_wlo;
    logic [WIDTH-1:0] r_opnd;
    logic [SHW-1:0]   r_cnt;

    logic [SHW-1:0]   w_shamt;
    logic             w_legal;
    logic             w_is_mul;
    logic             w_is_div;
    logic [WIDTH-1:0] w_res;
    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH:0]   w_div_sh;
    logic [WIDTH:0]   w_div_diff;
    logic [WIDTH-1:0] w_iter_hi;
    logic [WIDTH-1:0] w_iter_lo;

    // Decode alu_op/funct and compute the single-cycle result.
    always_comb begin
        w_legal  = 1'b1;
        w_is_mul = 1'b0;
        w_is_div = 1'b0;
        w_res    = '0;
        w_shamt  = src_b[SHW-1:0];
        case (alu_op)
            2'b00: w_res = src_a + src_b;
            2'b01: w_res = src_a - src_b;
            2'b10: begin
                case (funct)
                    6'b100000: w_res = src_a + src_b;
                    6'b100010: w_res = src_a - src_b;
                    6'b100100: w_res = src_a & src_b;
                    6'b100101: w_res = src_a | src_b;
                    6'b100110: w_res = src_a ^ src_b;
                    6'b100111: w_res = ~(src_a | src_b);
                    6'b101010: w_res = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
                    6'b000000: w_res = src_a << w_shamt;
                    6'b000010: w_res = src_a >> w_shamt;
                    6'b011001: begin
                        if (ENABLE_MDU) w_is_mul = 1'b1;
                        else            w_legal  = 1'b0;
                    end
                    6'b011011: begin
                        // All-ones is the divide-by-zero result; the
                        // iterative path overwrites it on completion.
                        if (ENABLE_MDU) begin
                            w_is_div = 1'b1;
                            w_res    = '1;
                        end else begin
                            w_legal  = 1'b0;
                        end
                    end
                    6'b010000: begin
                        if (ENABLE_MDU) w_res   = r_hi;
                        else            w_legal = 1'b0;
                    end
                    6'b010010: begin
                        if (ENABLE_MDU) w_res   = r_lo;
                        else            w_legal = 1'b0;
                    end
                    default: w_legal = 1'b0;
                endcase
            end
            default: w_legal = 1'b0;
        endcase
        if (!w_legal) w_res = '0;
    end

    // One shift-add multiply step or one restoring-divide step.
    always_comb begin
        w_mul_sum  = {1'b0, r_acc} + (r_wlo[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
        w_div_sh   = {r_acc, r_wlo[WIDTH-1]};
        w_div_diff = w_div_sh - {1'b0, r_opnd};
        if (r_state == S_MUL) begin
            w_iter_hi = w_mul_sum[WIDTH:1];
            w_iter_lo = {w_mul_sum[0], r_wlo[WIDTH-1:1]};
        end else if (!w_div_diff[WIDTH]) begin
            w_iter_hi = w_div_diff[WIDTH-1:0];
            w_iter_lo = {r_wlo[WIDTH-2:0], 1'b1};
        end else begin
            w_iter_hi = w_div_sh[WIDTH-1:0];
            w_iter_lo = {r_wlo[WIDTH-2:0], 1'b0};
        end
    end

    // Control FSM, operand capture, iteration and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_err       <= 1'b0;
            r_hi        <= '0;
            r_lo        <= '0;
            r_acc       <= '0;
            r_wlo       <= '0;
            r_opnd      <= '0;
            r_cnt       <= '0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        if (w_is_mul) begin
                            r_state    <= S_MUL;
                            r_in_ready <= 1'b0;
                            r_acc      <= '0;
                            r_wlo      <= src_b;
                            r_opnd     <= src_a;
                            r_cnt      <= '0;
                        end else if (w_is_div && (src_b != '0)) begin
                            r_state    <= S_DIV;
                            r_in_ready <= 1'b0;
                            r_acc      <= '0;
                            r_wlo      <= src_a;
                            r_opnd     <= src_b;
                            r_cnt      <= '0;
                        end else begin
                            r_out_valid <= 1'b1;
                            r_result    <= w_res;
                            r_zero      <= (w_res == '0);
                            r_err       <= !w_legal;
                            if (w_is_div) begin
                                r_hi <= src_a;
                                r_lo <= '1;
                            end
                        end
                    end
                end
                S_MUL, S_DIV: begin
                    r_acc <= w_iter_hi;
                    r_wlo <= w_iter_lo;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST_ITER) begin
                        r_state     <= S_IDLE;
                        r_in_ready  <= 1'b1;
                        r_out_valid <= 1'b1;
                        r_hi        <= w_iter_hi;
                        r_lo        <= w_iter_lo;
                        r_result    <= w_iter_lo;
                        r_zero      <= (w_iter_lo == '0);
                        r_err       <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign zero      = r_zero;
    assign err       = r_err;
    assign hi        = r_hi;
    assign lo        = r_lo;
    assign dbg_state = r_state;

endmodule
